// File: rtl/so_rr_arb.sv
// ----------------------------------------------------------------------------
// so_rr_arb -- round-robin arbiter with registered, held grant
//
// Purpose:
//    Grants one of DATA requesters at a time. A grant, once issued, is held
//    until the owner pulses rel (or, optionally, until a timeout forces it
//    off). On release the priority pointer moves to the requester just after
//    the one that was granted, so a continuously requesting client is served
//    within DATA grants. A new grant can be issued on the same edge as the
//    release, so back-to-back grants have no idle cycle.
//
// Optional feature:
//    SO_RR_ARB_TIMEOUT_EN -- when defined, a grant held for TIMEOUT cycles
//    without rel is forcibly released and to_err pulses for that cycle.
//    When undefined, there is no counter, TIMEOUT is unused and to_err is 0.
//
// Parameters:
//    DATA    -- number of requesters (2..64)
//    TIMEOUT -- maximum grant hold in cycles (2..65535), timeout build only
//
// Ports:
//    clk      in   single clock, rising edge
//    rstN     in   synchronous active-low reset
//    req      in   request vector, bit i is requester i
//    rel      in   one-cycle release of the current grant
//    gnt      out  registered one-hot (or zero) grant
//    gnt_vld  out  registered, high while gnt is non-zero
//    gnt_idx  out  registered binary index of the granted bit, 0 when idle
//    to_err   out  one-cycle pulse in the cycle a timeout forces a release
// ----------------------------------------------------------------------------
module so_rr_arb #(
   parameter int DATA    = 4,
   parameter int TIMEOUT = 256
) (
   input  logic                    clk,
   input  logic                    rstN,
   input  logic [DATA-1:0]         req,
   input  logic                    rel,
   output logic [DATA-1:0]         gnt,
   output logic                    gnt_vld,
   output logic [$clog2(DATA)-1:0] gnt_idx,
   output logic                    to_err
);

   localparam int IW = $clog2(DATA);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [DATA-1:0] gnt_q, gnt_d;
   logic            vld_q, vld_d;

   logic [IW-1:0]   nextPtr;
   logic [IW-1:0]   base;
   logic [IW:0]     pickVec;
   logic            pickFound;
   logic [IW-1:0]   pickIdx;
   logic            relEff;
   logic            forceRel;

   // Reject out-of-range configurations at elaboration time.
   if (DATA < 2 || DATA > 64 || TIMEOUT < 2 || TIMEOUT > 65535) begin : gBadParams
      $error("so_rr_arb: DATA or TIMEOUT parameter out of range");
   end

   // Search the request vector in wrap order starting at 'start' and return
   // {found, index} of the first set bit.
   function automatic logic [IW:0] pickNext(input logic [DATA-1:0] r,
                                            input logic [IW-1:0]   start);
      logic          found;
      logic [IW-1:0] sel;
      logic [IW-1:0] cand;
      int            pos;
      found = 1'b0;
      sel   = '0;
      for (int k = 0; k < DATA; k++) begin
         pos = int'(start) + k;
         if (pos >= DATA) pos = pos - DATA;
         cand = pos[IW-1:0];
         if (!found && r[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
      return {found, sel};
   endfunction

`ifdef SO_RR_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // The counter reads 1 in the first grant cycle, so reaching TIMEOUT means
   // the grant has been visible for exactly TIMEOUT cycles.
   assign forceRel = (state_q == GRANT) && (cnt_q == CW'(TIMEOUT));

   // A release that coincides with the timeout is an ordinary release, and a
   // reset edge never reports a timeout.
   assign to_err   = rstN && forceRel && !rel;
`else
   assign forceRel = 1'b0;
   assign to_err   = 1'b0;
`endif

   // Pointer after a release: one past the requester being released.
   assign nextPtr = (idx_q == IW'(DATA - 1)) ? '0 : idx_q + 1'b1;

   // Next-state logic. On a release the search starts from the advanced
   // pointer so a waiting requester can be granted on the same edge.
   always_comb begin
      relEff    = (state_q == GRANT) && (rel || forceRel);
      base      = relEff ? nextPtr : ptr_q;
      pickVec   = pickNext(req, base);
      pickFound = pickVec[IW];
      pickIdx   = pickVec[IW-1:0];

      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      vld_d   = vld_q;
`ifdef SO_RR_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif

      case (state_q)
         IDLE: begin
            if (pickFound) begin
               state_d          = GRANT;
               gnt_d            = '0;
               gnt_d[pickIdx]   = 1'b1;
               idx_d            = pickIdx;
               vld_d            = 1'b1;
`ifdef SO_RR_ARB_TIMEOUT_EN
               cnt_d            = CW'(1);
`endif
            end
         end
         GRANT: begin
            if (relEff) begin
               ptr_d = nextPtr;
               if (pickFound) begin
                  gnt_d          = '0;
                  gnt_d[pickIdx] = 1'b1;
                  idx_d          = pickIdx;
                  vld_d          = 1'b1;
`ifdef SO_RR_ARB_TIMEOUT_EN
                  cnt_d          = CW'(1);
`endif
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
                  idx_d   = '0;
                  vld_d   = 1'b0;
`ifdef SO_RR_ARB_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end
            end else begin
`ifdef SO_RR_ARB_TIMEOUT_EN
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any grant without moving the
   // pointer forward.
   always_ff @(posedge clk) begin
      if (!rstN) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gnt_q   <= '0;
         idx_q   <= '0;
         vld_q   <= 1'b0;
`ifdef SO_RR_ARB_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         vld_q   <= vld_d;
`ifdef SO_RR_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign gnt     = gnt_q;
   assign gnt_vld = vld_q;
   assign gnt_idx = idx_q;

endmodule

// File: tb/tb_so_rr_arb.sv
// ----------------------------------------------------------------------------
// tb_so_rr_arb -- self-checking bench for so_rr_arb
//
// Three arbiters (DATA = 4, 2, 64) share a clock and reset. The DATA=4 unit
// is driven first through a table of directed vectors, then a timeout (or
// long-hold) sequence, and finally all three run random req/rel traffic
// against a behavioural round-robin model.
// ----------------------------------------------------------------------------
module tb_so_rr_arb;

   localparam int TO4  = 4;
   localparam int TO2  = 6;
   localparam int TO64 = 9;

`ifdef SO_RR_ARB_TIMEOUT_EN
   localparam bit TOEN = 1'b1;
`else
   localparam bit TOEN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstN;

   logic [3:0]  req4, gnt4;
   logic        rel4, vld4, err4;
   logic [1:0]  idx4;

   logic [1:0]  req2, gnt2;
   logic        rel2, vld2, err2;
   logic [0:0]  idx2;

   logic [63:0] req64, gnt64;
   logic        rel64, vld64, err64;
   logic [5:0]  idx64;

   int nCompared   = 0;
   int nMismatched = 0;

   so_rr_arb #(.DATA(4), .TIMEOUT(TO4)) u4 (
      .clk(clk), .rstN(rstN), .req(req4), .rel(rel4),
      .gnt(gnt4), .gnt_vld(vld4), .gnt_idx(idx4), .to_err(err4)
   );

   so_rr_arb #(.DATA(2), .TIMEOUT(TO2)) u2 (
      .clk(clk), .rstN(rstN), .req(req2), .rel(rel2),
      .gnt(gnt2), .gnt_vld(vld2), .gnt_idx(idx2), .to_err(err2)
   );

   so_rr_arb #(.DATA(64), .TIMEOUT(TO64)) u64 (
      .clk(clk), .rstN(rstN), .req(req64), .rel(rel64),
      .gnt(gnt64), .gnt_vld(vld64), .gnt_idx(idx64), .to_err(err64)
   );

   // Directed vector: inputs applied before an edge, outputs expected after it.
   typedef struct {
      logic       rstN;
      logic [3:0] req;
      logic       rel;
      logic [3:0] gnt;
      logic [1:0] idx;
      logic       vld;
   } vec_t;

   vec_t vecs[19];

   // Behavioural model state, one slot per arbiter (0: DATA=4, 1: 2, 2: 64).
   int nReq[3] = '{4, 2, 64};
   int tmo[3]  = '{TO4, TO2, TO64};
   int mHold[3];
   int mIdx[3];
   int mPtr[3];
   int mAge[3];

   // Starvation tracking: grants to others seen while a requester waits.
   int          waitCnt[3][64];
   int          maxWait[3];
   logic [63:0] prevGnt[3];

   // Compare one value and report it if it differs.
   task automatic checkOutput(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t",
                  name, act, exp, $time);
      end
   endtask

   // Drive the DATA=4 unit for one cycle and stop just after the edge.
   task automatic applyStimulus(input logic r, input logic [3:0] q, input logic l);
      rstN = r;
      req4 = q;
      rel4 = l;
      @(posedge clk);
      #1;
   endtask

   // Round-robin rules: grant the first requester at or after the pointer,
   // hold until release (or timeout), then advance the pointer past the
   // released requester and re-arbitrate on the same edge.
   function automatic void modelStep(input int d, input logic [63:0] r,
                                     input logic l, input logic rs);
      int n;
      bit fire;
      n = nReq[d];
      if (!rs) begin
         mHold[d] = 0; mIdx[d] = 0; mPtr[d] = 0; mAge[d] = 0;
         return;
      end
      if (mHold[d] != 0) begin
         fire = l || (TOEN && mAge[d] == tmo[d]);
         if (!fire) begin
            mAge[d]++;
            return;
         end
         mPtr[d]  = (mIdx[d] + 1) % n;
         mHold[d] = 0;
         mIdx[d]  = 0;
         mAge[d]  = 0;
      end
      for (int k = 0; k < n; k++) begin
         int p;
         p = (mPtr[d] + k) % n;
         if (r[p]) begin
            mHold[d] = 1;
            mIdx[d]  = p;
            mAge[d]  = 1;
            return;
         end
      end
   endfunction

   // Compare one arbiter against the model plus grant-shape properties.
   task automatic checkUnit(input int d, input string tag, input logic [63:0] g,
                            input int idx, input logic vld, input logic err,
                            input logic [63:0] r, input logic l);
      logic [63:0] expG;
      logic        expErr;
      int          idxFromG;
      expG   = (mHold[d] != 0) ? (64'd1 << mIdx[d]) : 64'd0;
      expErr = TOEN && rstN && (mHold[d] != 0) && (mAge[d] == tmo[d]) && !l;
      checkOutput({tag, "_gnt"}, g, expG);
      checkOutput({tag, "_idx"}, 64'(idx), 64'(mIdx[d]));
      checkOutput({tag, "_vld"}, 64'(vld), 64'(mHold[d] != 0));
      checkOutput({tag, "_to_err"}, 64'(err), 64'(expErr));
      checkOutput({tag, "_onehot"}, 64'($countones(g) <= 1), 64'd1);
      idxFromG = 0;
      for (int i = 0; i < 64; i++) if (g[i]) idxFromG = i;
      checkOutput({tag, "_idx_vs_gnt"}, 64'(idx), 64'(idxFromG));
      checkOutput({tag, "_vld_vs_gnt"}, 64'(vld), 64'(g != 0));
      for (int i = 0; i < nReq[d]; i++) begin
         if (!rstN || !r[i] || g[i]) waitCnt[d][i] = 0;
         else if (g != 0 && g != prevGnt[d]) waitCnt[d][i]++;
         if (waitCnt[d][i] > maxWait[d]) maxWait[d] = waitCnt[d][i];
      end
      prevGnt[d] = g;
   endtask

   // Safety net in case the run stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
      vecs[1]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0};
      vecs[2]  = '{1'b1, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1};
      vecs[3]  = '{1'b1, 4'b1010, 1'b1, 4'b1000, 2'd3, 1'b1};
      vecs[4]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1};
      vecs[5]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1};
      vecs[6]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1};
      vecs[7]  = '{1'b1, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1};
      vecs[8]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1};
      vecs[9]  = '{1'b1, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1};
      vecs[10] = '{1'b1, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1};
      vecs[11] = '{1'b1, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1};
      vecs[12] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
      vecs[13] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
      vecs[14] = '{1'b1, 4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1};
      vecs[15] = '{1'b0, 4'b1001, 1'b0, 4'b0000, 2'd0, 1'b0};
      vecs[16] = '{1'b1, 4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1};
      vecs[17] = '{1'b1, 4'b1001, 1'b1, 4'b1000, 2'd3, 1'b1};
      vecs[18] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};

      rstN  = 1'b0;
      req4  = '0; rel4  = 1'b0;
      req2  = '0; rel2  = 1'b0;
      req64 = '0; rel64 = 1'b0;

      $display("[TB] directed vectors on DATA=4");
      for (int v = 0; v < 19; v++) begin
         applyStimulus(vecs[v].rstN, vecs[v].req, vecs[v].rel);
         checkOutput($sformatf("vec%0d_gnt", v), 64'(gnt4), 64'(vecs[v].gnt));
         checkOutput($sformatf("vec%0d_idx", v), 64'(idx4), 64'(vecs[v].idx));
         checkOutput($sformatf("vec%0d_vld", v), 64'(vld4), 64'(vecs[v].vld));
         checkOutput($sformatf("vec%0d_to_err", v), 64'(err4), 64'd0);
      end

`ifdef SO_RR_ARB_TIMEOUT_EN
      $display("[TB] timeout sequence, TIMEOUT=%0d", TO4);
      for (int c = 1; c <= TO4; c++) begin
         applyStimulus(1'b1, 4'b0011, 1'b0);
         checkOutput($sformatf("to_hold%0d_gnt", c), 64'(gnt4), 64'b0001);
         checkOutput($sformatf("to_hold%0d_err", c), 64'(err4), 64'(c == TO4));
      end
      applyStimulus(1'b1, 4'b0011, 1'b0);
      checkOutput("to_next_gnt", 64'(gnt4), 64'b0010);
      checkOutput("to_next_idx", 64'(idx4), 64'd1);
      checkOutput("to_next_err", 64'(err4), 64'd0);
      for (int c = 2; c < TO4; c++) begin
         applyStimulus(1'b1, 4'b0011, 1'b0);
         checkOutput($sformatf("to_reload%0d_err", c), 64'(err4), 64'd0);
      end
      applyStimulus(1'b1, 4'b0011, 1'b0);
      checkOutput("to_reload_last_gnt", 64'(gnt4), 64'b0010);
      rel4 = 1'b1;
      #1;
      checkOutput("to_with_rel_err", 64'(err4), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("to_with_rel_gnt", 64'(gnt4), 64'b0001);
      checkOutput("to_with_rel_err2", 64'(err4), 64'd0);
      applyStimulus(1'b1, 4'b0000, 1'b1);
      checkOutput("to_cleanup_gnt", 64'(gnt4), 64'd0);
`else
      $display("[TB] long hold without timeout");
      for (int c = 1; c <= 1000; c++) begin
         applyStimulus(1'b1, 4'b0011, 1'b0);
         checkOutput($sformatf("hold%0d_gnt", c), 64'(gnt4), 64'b0001);
         checkOutput($sformatf("hold%0d_err", c), 64'(err4), 64'd0);
      end
      applyStimulus(1'b1, 4'b0011, 1'b1);
      checkOutput("hold_release_gnt", 64'(gnt4), 64'b0010);
      applyStimulus(1'b1, 4'b0000, 1'b1);
      checkOutput("hold_cleanup_gnt", 64'(gnt4), 64'd0);
`endif

      $display("[TB] random traffic on DATA=4, 2, 64");
      for (int d = 0; d < 3; d++) begin
         maxWait[d] = 0;
         prevGnt[d] = '0;
         for (int i = 0; i < 64; i++) waitCnt[d][i] = 0;
      end
      for (int cyc = 0; cyc < 10000; cyc++) begin
         rstN = (cyc == 0) ? 1'b0 : ($urandom_range(0, 999) != 0);
         for (int b = 0; b < 4; b++)  if ($urandom_range(0, 7) == 0) req4[b]  = ~req4[b];
         for (int b = 0; b < 2; b++)  if ($urandom_range(0, 7) == 0) req2[b]  = ~req2[b];
         for (int b = 0; b < 64; b++) if ($urandom_range(0, 7) == 0) req64[b] = ~req64[b];
         rel4  = ($urandom_range(0, 5) == 0);
         rel2  = ($urandom_range(0, 5) == 0);
         rel64 = ($urandom_range(0, 5) == 0);
         @(posedge clk);
         modelStep(0, {60'd0, req4}, rel4, rstN);
         modelStep(1, {62'd0, req2}, rel2, rstN);
         modelStep(2, req64, rel64, rstN);
         #1;
         checkUnit(0, "r4",  {60'd0, gnt4}, int'(idx4),  vld4,  err4,  {60'd0, req4}, rel4);
         checkUnit(1, "r2",  {62'd0, gnt2}, int'(idx2),  vld2,  err2,  {62'd0, req2}, rel2);
         checkUnit(2, "r64", gnt64,         int'(idx64), vld64, err64, req64,         rel64);
      end
      for (int d = 0; d < 3; d++) begin
         checkOutput($sformatf("starve_u%0d", nReq[d]), 64'(maxWait[d] <= nReq[d]), 64'd1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
